hamming_scrub_ctrl: RTL and testbench

Controller that owns a small Hamming(7,4)-protected storage array and sequences the team's (7,4) encoder/decoder datapath around it. It serves host writes and reads through valid/ready handshakes and, when the host is idle, runs a background scrubber. The scrubber walks the array, decodes each word, and writes corrected codewords back. It sits between the host-side register interface and the protected storage.

---
 rtl/hamming_scrub_ctrl.sv | 158 +++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: Hamming(7,4)-protected storage array with host
// write/read ports and an idle-time background scrubber that corrects
// single-bit errors in place.
// Optional feature macro: HSC_ERR_INJECT_EN adds the inj_mask port, whose
// value is XORed into every host-written codeword (scrub write-backs are
// never masked).
module hamming_scrub_ctrl #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 8,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [3:0]        rd_data,
    output logic              rd_err,
    input  logic              scrub_en,
    output logic [CNT_W-1:0]  corr_cnt
`ifdef HSC_ERR_INJECT_EN
    ,
    input  logic [6:0]        inj_mask
`endif
);

    localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    typedef enum logic [1:0] {IDLE, SCRUB_CHK, SCRUB_WB} state_t;

    // Codeword layout: {d3,d2,d1,p4,d0,p2,p1}
    function automatic logic [6:0] henc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
                d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // Syndrome {p4,p2,p1}; a nonzero value is the 1-based position of the bad bit
    function automatic logic [2:0] hsyn(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6],
                c[1] ^ c[2] ^ c[5] ^ c[6],
                c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    function automatic logic [3:0] hdec(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] f;
        s = hsyn(c);
        f = c;
        if (s != 3'd0) f = c ^ (7'd1 << (s - 3'd1));
        return {f[6], f[5], f[4], f[2]};
    endfunction

    state_t            state, next_state;
    logic [6:0]        mem [DEPTH];
    logic [ADDR_W-1:0] scrub_ptr;
    logic [IW-1:0]     icnt;

    logic [6:0] wr_cw, rd_cw, sc_cw;
    logic [2:0] rd_syn, sc_syn;
    logic       wr_hs, rd_hs, host_req, start_scrub, ptr_adv, corr_inc;

`ifdef HSC_ERR_INJECT_EN
    assign wr_cw = henc(wr_data) ^ inj_mask;
`else
    assign wr_cw = henc(wr_data);
`endif

    assign rd_cw    = mem[rd_addr];
    assign sc_cw    = mem[scrub_ptr];
    assign rd_syn   = hsyn(rd_cw);
    assign sc_syn   = hsyn(sc_cw);
    assign wr_hs    = wr_valid && wr_ready;
    assign rd_hs    = rd_valid && rd_ready;
    assign host_req = wr_valid || rd_valid;

    // A scrub step only begins on a fully idle host cycle
    assign start_scrub = (state == IDLE) && scrub_en && !host_req &&
                         (icnt == IW'(SCRUB_INTERVAL - 1));
    assign ptr_adv     = ((state == SCRUB_CHK) && (sc_syn == 3'd0)) || (state == SCRUB_WB);
    // Host and scrub corrections cannot coincide (WB is not IDLE), so OR counts once
    assign corr_inc    = (rd_hs && (rd_syn != 3'd0)) || (state == SCRUB_WB);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and handshake readies; writes win over reads
    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                rd_ready = !wr_valid;
                if (start_scrub) next_state = SCRUB_CHK;
            end
            SCRUB_CHK: next_state = (sc_syn != 3'd0) ? SCRUB_WB : IDLE;
            SCRUB_WB:  next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Storage: host writes in IDLE, corrected write-back in SCRUB_WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 7'd0;
        end else if (wr_hs) begin
            mem[wr_addr] <= wr_cw;
        end else if (state == SCRUB_WB) begin
            mem[scrub_ptr] <= henc(hdec(sc_cw));
        end
    end

    // Scrub pointer and idle interval counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scrub_ptr <= '0;
            icnt      <= '0;
        end else begin
            if (ptr_adv) scrub_ptr <= scrub_ptr + 1'b1;
            if (!scrub_en || wr_hs || rd_hs || start_scrub)
                icnt <= '0;
            else if (state == IDLE && !host_req)
                icnt <= icnt + 1'b1;
        end
    end

    // Registered read response; data/err hold until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_resp_valid <= 1'b0;
            rd_data       <= 4'd0;
            rd_err        <= 1'b0;
        end else begin
            rd_resp_valid <= rd_hs;
            if (rd_hs) begin
                rd_data <= hdec(rd_cw);
                rd_err  <= (rd_syn != 3'd0);
            end
        end
    end

    // Saturating correction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            corr_cnt <= '0;
        else if (corr_inc && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: vector table for write/read
// pairs plus hand-written sequences for arbitration, scrub timing, stalls
// and reset. Error-injection sequences need HSC_ERR_INJECT_EN.
module tb_hamming_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0, rd_valid = 1'b0, scrub_en = 1'b0;
    logic [3:0] wr_addr = '0, rd_addr = '0, wr_data = '0;
    logic       wr_ready, rd_ready, rd_resp_valid, rd_err;
    logic [3:0] rd_data;
    logic [7:0] corr_cnt;
`ifdef HSC_ERR_INJECT_EN
    logic [6:0] inj = '0;
`endif

    hamming_scrub_ctrl #(.DEPTH(16), .ADDR_W(4), .SCRUB_INTERVAL(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_err(rd_err),
        .scrub_en(scrub_en), .corr_cnt(corr_cnt)
`ifdef HSC_ERR_INJECT_EN
        , .inj_mask(inj)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_rd;
        logic [3:0] addr;
        logic [3:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs[10];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic host_write(input logic [3:0] a, input logic [3:0] d, output int waits);
        wr_addr = a; wr_data = d; wr_valid = 1'b1; waits = 0;
        #1;
        while (!wr_ready && waits < 8) begin @(negedge clk); #1; waits++; end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge when the response is due
    task automatic host_read(input logic [3:0] a, output logic [3:0] d, output logic e,
                             output logic v, output int waits);
        rd_addr = a; rd_valid = 1'b1; waits = 0;
        #1;
        while (!rd_ready && waits < 8) begin @(negedge clk); #1; waits++; end
        @(negedge clk);
        v = rd_resp_valid; d = rd_data; e = rd_err;
        rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        logic [3:0] d;
        logic       e, v;
        int         w, busy, first_busy, found;

        vecs[0] = '{1'b0, 4'd0,  4'h1};
        vecs[1] = '{1'b0, 4'd15, 4'hF};
        vecs[2] = '{1'b0, 4'd8,  4'h5};
        vecs[3] = '{1'b0, 4'd0,  4'hE};
        vecs[4] = '{1'b1, 4'd0,  4'hE};
        vecs[5] = '{1'b1, 4'd15, 4'hF};
        vecs[6] = '{1'b1, 4'd8,  4'h5};
        vecs[7] = '{1'b0, 4'd1,  4'h0};
        vecs[8] = '{1'b1, 4'd1,  4'h0};
        vecs[9] = '{1'b1, 4'd9,  4'h0};

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        @(negedge clk);

        // Basic write/read with latency and single-cycle response pulse
        host_write(4'd3, 4'hA, w);
        host_read(4'd3, d, e, v, w);
        chk("rd3_valid", v, 1);
        chk("rd3_data", d, 4'hA);
        chk("rd3_err", e, 0);
        @(negedge clk);
        chk("rd3_pulse_end", rd_resp_valid, 0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].is_rd) begin
                host_write(vecs[i].addr, vecs[i].data, w);
                chk($sformatf("vec%0d_wr_wait", i), w, 0);
            end else begin
                host_read(vecs[i].addr, d, e, v, w);
                chk($sformatf("vec%0d_valid", i), v, 1);
                chk($sformatf("vec%0d_data", i), d, vecs[i].data);
                chk($sformatf("vec%0d_err", i), e, 0);
            end
        end

        // Simultaneous write and read to the same address: write wins
        wr_addr = 4'd7; wr_data = 4'hC; wr_valid = 1'b1;
        rd_addr = 4'd7; rd_valid = 1'b1;
        #1;
        chk("sim_rd_ready_low", rd_ready, 0);
        chk("sim_wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("sim_rd_ready_now", rd_ready, 1);
        chk("sim_no_resp_yet", rd_resp_valid, 0);
        @(negedge clk);
        chk("sim_resp_valid", rd_resp_valid, 1);
        chk("sim_resp_data", rd_data, 4'hC);
        rd_valid = 1'b0;

        // Scrub cadence on a clean array: first step after 8 idle cycles,
        // then one 1-cycle step every 9 cycles
        scrub_en = 1'b1;
        busy = 0; first_busy = -1;
        for (int i = 1; i <= 144; i++) begin
            @(negedge clk);
            if (!wr_ready) begin
                busy++;
                if (first_busy < 0) first_busy = i;
            end
        end
        chk("scrub_first_step", first_busy, 8);
        chk("scrub_sweep_steps", busy, 16);
        chk("scrub_clean_cnt", corr_cnt, 0);

        // Host write arriving during a clean SCRUB_CHK stalls one cycle
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!wr_ready) found = 1;
        end
        chk("chk_seen", found, 1);
        host_write(4'd2, 4'h9, w);
        chk("chk_stall_cycles", w, 1);
        scrub_en = 1'b0;
        host_read(4'd2, d, e, v, w);
        chk("chk_wr_kept", d, 4'h9);

`ifdef HSC_ERR_INJECT_EN
        // Injected single-bit error corrected on host read
        do_reset();
        inj = 7'b0010000;
        host_write(4'd5, 4'h6, w);
        inj = 7'b0;
        host_read(4'd5, d, e, v, w);
        chk("inj_rd_data", d, 4'h6);
        chk("inj_rd_err", e, 1);
        chk("inj_cnt1", corr_cnt, 1);

        // Scrubber reaches addr 5 and writes it back (2-cycle step)
        scrub_en = 1'b1;
        busy = 0; first_busy = 0;
        for (int i = 0; i < 200 && corr_cnt != 8'd2; i++) begin
            @(negedge clk);
            if (!wr_ready) busy++; else busy = 0;
            if (busy > first_busy) first_busy = busy;
        end
        scrub_en = 1'b0;
        chk("scrub_cnt2", corr_cnt, 2);
        chk("scrub_wb_run", first_busy, 2);
        host_read(4'd5, d, e, v, w);
        chk("scrub_fixed_data", d, 4'h6);
        chk("scrub_fixed_err", e, 0);

        // Host request during SCRUB_CHK of a corrupted word: 2-cycle stall
        do_reset();
        inj = 7'b0010000;
        host_write(4'd0, 4'h3, w);
        inj = 7'b0;
        scrub_en = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!wr_ready) found = 1;
        end
        host_write(4'd1, 4'h3, w);
        chk("bad_chk_stall", w, 2);
        scrub_en = 1'b0;
        host_read(4'd1, d, e, v, w);
        chk("bad_chk_wr_kept", d, 4'h3);
        chk("bad_chk_cnt", corr_cnt, 1);

        // Counter saturation
        inj = 7'b0010000;
        host_write(4'd4, 4'h5, w);
        inj = 7'b0;
        for (int i = 0; i < 259; i++) host_read(4'd4, d, e, v, w);
        chk("sat_cnt", corr_cnt, 8'd255);
        chk("sat_last_err", e, 1);
`endif

        // Reset asserted mid-scrub takes effect immediately
        scrub_en = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!wr_ready) found = 1;
        end
        chk("mid_scrub_seen", found, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_ready", wr_ready, 1);
        chk("mid_rst_rd_ready", rd_ready, 1);
        chk("mid_rst_resp", rd_resp_valid, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_err", rd_err, 0);
        chk("mid_rst_cnt", corr_cnt, 0);
        scrub_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        host_read(4'd2, d, e, v, w);
        chk("post_rst_mem", d, 4'h0);
        chk("post_rst_err", e, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
